// File: rtl/fetch_prefetch_queue_if.sv
// Signal bundle linking the fetch stage to Decode/EX control and to the instruction memory controller.
// The fetch stage connects through the master modport and its environment through the slave modport.
interface fetch_prefetch_queue_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  ex_if_stall;
  logic                  id_if_selpcsource;
  logic [1:0]            id_if_selpctype;
  logic [ADDR_WIDTH-1:0] id_if_rega;
  logic [ADDR_WIDTH-1:0] id_if_pcimd2ext;
  logic [ADDR_WIDTH-1:0] id_if_pcindex;
  logic [DATA_WIDTH-1:0] if_id_instruc;
  logic [ADDR_WIDTH-1:0] if_id_nextpc;
  logic                  if_id_valid;
  logic                  if_mc_en;
  logic [ADDR_WIDTH-1:0] if_mc_addr;
  logic                  mc_if_valid;
  logic [DATA_WIDTH-1:0] mc_if_data;

  modport master (
    input  ex_if_stall, id_if_selpcsource, id_if_selpctype,
    input  id_if_rega, id_if_pcimd2ext, id_if_pcindex,
    input  mc_if_valid, mc_if_data,
    output if_id_instruc, if_id_nextpc, if_id_valid,
    output if_mc_en, if_mc_addr
  );

  modport slave (
    output ex_if_stall, id_if_selpcsource, id_if_selpctype,
    output id_if_rega, id_if_pcimd2ext, id_if_pcindex,
    output mc_if_valid, mc_if_data,
    input  if_id_instruc, if_id_nextpc, if_id_valid,
    input  if_mc_en, if_mc_addr
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch stage with a DEPTH-entry prefetch queue over an in-order, variable-latency memory port.
// Redirects flush the queue; responses still in flight at a redirect are counted and dropped on return.
module fetch_prefetch_queue #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR = ADDR_WIDTH'(64)
) (
  input  logic                   clock,
  input  logic                   reset,
  fetch_prefetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [CW:0]           DEPTH_LIM = (CW + 1)'(DEPTH);

  typedef enum logic {MODE_FETCH, MODE_DRAIN} mode_e;

  mode_e                 mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [CW-1:0]         discard_q, discard_d;
  logic [PW-1:0]         q_head_q, q_head_d, q_tail_q, q_tail_d;
  logic [PW-1:0]         a_head_q, a_head_d, a_tail_q, a_tail_d;
  logic [DATA_WIDTH-1:0] if_id_instruc_q, if_id_instruc_d;
  logic [ADDR_WIDTH-1:0] if_id_nextpc_q, if_id_nextpc_d;
  logic                  if_id_valid_q, if_id_valid_d;

  // Buffered words with their next-PC, and the PCs of every read still in flight.
  logic [DATA_WIDTH-1:0] q_data [DEPTH];
  logic [ADDR_WIDTH-1:0] q_npc  [DEPTH];
  logic [ADDR_WIDTH-1:0] a_pc   [DEPTH];

  logic                  redirect, issue, resp, keep, pop, bypass, push;
  logic [ADDR_WIDTH-1:0] target, resp_npc;
  logic [CW:0]           credit_sum;

  always_comb begin
    redirect        = bus.id_if_selpcsource & ~bus.ex_if_stall;
    credit_sum      = {1'b0, count_q} + {1'b0, outstanding_q};
    issue           = ~reset & ~redirect & (credit_sum < DEPTH_LIM);
    resp            = bus.mc_if_valid & (outstanding_q != '0);
    keep            = resp & (mode_q == MODE_FETCH) & ~redirect;
    resp_npc        = a_pc[a_head_q] + STEP;
    pop             = ~bus.ex_if_stall & ~redirect & (count_q != '0);
    bypass          = ~bus.ex_if_stall & ~redirect & (count_q == '0) & keep;
    push            = keep & ~bypass;

    target          = EXC_VECTOR;
    mode_d          = mode_q;
    pc_d            = pc_q;
    count_d         = count_q;
    outstanding_d   = outstanding_q + CW'(issue) - CW'(resp);
    discard_d       = discard_q;
    q_head_d        = q_head_q + PW'(pop);
    q_tail_d        = q_tail_q + PW'(push);
    a_head_d        = a_head_q + PW'(resp);
    a_tail_d        = a_tail_q + PW'(issue);
    if_id_instruc_d = if_id_instruc_q;
    if_id_nextpc_d  = if_id_nextpc_q;
    if_id_valid_d   = if_id_valid_q;

    case (bus.id_if_selpctype)
      2'b00:   target = bus.id_if_pcimd2ext;
      2'b01:   target = bus.id_if_rega;
      2'b10:   target = bus.id_if_pcindex;
      default: target = EXC_VECTOR;
    endcase

    if (redirect) begin
      // Everything still in flight after this cycle is stale, including reads
      // that were already stale from an earlier redirect.
      pc_d            = target;
      count_d         = '0;
      q_head_d        = '0;
      q_tail_d        = '0;
      discard_d       = outstanding_q - CW'(resp);
      if_id_instruc_d = '0;
      if_id_nextpc_d  = '0;
      if_id_valid_d   = 1'b0;
    end else begin
      if (issue) begin
        pc_d = pc_q + STEP;
      end
      if (resp && mode_q == MODE_DRAIN) begin
        discard_d = discard_q - 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
      if (!bus.ex_if_stall) begin
        if (pop) begin
          if_id_instruc_d = q_data[q_head_q];
          if_id_nextpc_d  = q_npc[q_head_q];
          if_id_valid_d   = 1'b1;
        end else if (bypass) begin
          if_id_instruc_d = bus.mc_if_data;
          if_id_nextpc_d  = resp_npc;
          if_id_valid_d   = 1'b1;
        end else begin
          if_id_instruc_d = '0;
          if_id_valid_d   = 1'b0;
        end
      end
    end

    mode_d = (discard_d == '0) ? MODE_FETCH : MODE_DRAIN;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q          <= MODE_FETCH;
      pc_q            <= RESET_PC;
      count_q         <= '0;
      outstanding_q   <= '0;
      discard_q       <= '0;
      q_head_q        <= '0;
      q_tail_q        <= '0;
      a_head_q        <= '0;
      a_tail_q        <= '0;
      if_id_instruc_q <= '0;
      if_id_nextpc_q  <= '0;
      if_id_valid_q   <= 1'b0;
    end else begin
      mode_q          <= mode_d;
      pc_q            <= pc_d;
      count_q         <= count_d;
      outstanding_q   <= outstanding_d;
      discard_q       <= discard_d;
      q_head_q        <= q_head_d;
      q_tail_q        <= q_tail_d;
      a_head_q        <= a_head_d;
      a_tail_q        <= a_tail_d;
      if_id_instruc_q <= if_id_instruc_d;
      if_id_nextpc_q  <= if_id_nextpc_d;
      if_id_valid_q   <= if_id_valid_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      q_data[q_tail_q] <= bus.mc_if_data;
      q_npc[q_tail_q]  <= resp_npc;
    end
    if (issue) begin
      a_pc[a_tail_q] <= pc_q;
    end
  end

  assign bus.if_mc_en      = issue;
  assign bus.if_mc_addr    = pc_q;
  assign bus.if_id_instruc = if_id_instruc_q;
  assign bus.if_id_nextpc  = if_id_nextpc_q;
  assign bus.if_id_valid   = if_id_valid_q;
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed and randomized bench for fetch_prefetch_queue against a word-stream reference model
// (expected program-order words per redirect generation, plus an in-order memory with configurable latency).
module tb_fetch_prefetch_queue;
  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] EXC   = 32'd64;

  logic clock = 1'b0;
  logic reset;

  fetch_prefetch_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fetch_prefetch_queue #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
    .RESET_PC(32'h0), .EXC_VECTOR(EXC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {logic [31:0] addr; int due; int gen;} req_t;
  typedef struct {logic [31:0] instr; logic [31:0] npc;} word_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          lat = 1;
  int          gen = 0;
  int          last_due = 0;
  int          issues = 0;
  req_t        mem_q[$];
  word_t       exp_q[$];
  logic [31:0] exp_req_pc = 32'h0;
  logic        last_en;

  function automatic logic [31:0] memword(logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock cycle: memory model drives a response, issue is sampled before the edge,
  // and Decode-side outputs are checked against the expected word stream after the edge.
  task automatic tick();
    req_t        r;
    logic        resp, redir, kept, exp_en;
    logic [31:0] tgt, pre_instr, pre_npc;
    logic        pre_valid;
    int          inflight_pre;
    word_t       w;
    r    = '{32'h0, 0, -1};
    resp = 1'b0;
    if (reset) begin
      mem_q.delete();
    end
    if (!reset && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      r    = mem_q.pop_front();
      resp = 1'b1;
      bus.mc_if_valid = 1'b1;
      bus.mc_if_data  = memword(r.addr);
    end else begin
      bus.mc_if_valid = 1'b0;
      bus.mc_if_data  = $urandom;
    end
    @(negedge clock);
    pre_instr    = bus.if_id_instruc;
    pre_npc      = bus.if_id_nextpc;
    pre_valid    = bus.if_id_valid;
    redir        = bus.id_if_selpcsource && !bus.ex_if_stall && !reset;
    inflight_pre = mem_q.size() + (resp ? 1 : 0);
    exp_en       = !reset && !redir && (exp_q.size() + inflight_pre < DEPTH);
    check("mc_en", 32'(bus.if_mc_en), 32'(exp_en));
    last_en = bus.if_mc_en;
    if (bus.if_mc_en) begin
      check("mc_addr", bus.if_mc_addr, exp_req_pc);
      last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      mem_q.push_back('{bus.if_mc_addr, last_due, gen});
      exp_req_pc = exp_req_pc + 32'd4;
      issues++;
    end
    kept = resp && (r.gen == gen) && !redir;
    if (redir) begin
      case (bus.id_if_selpctype)
        2'b00:   tgt = bus.id_if_pcimd2ext;
        2'b01:   tgt = bus.id_if_rega;
        2'b10:   tgt = bus.id_if_pcindex;
        default: tgt = EXC;
      endcase
      exp_req_pc = tgt;
      gen++;
      exp_q.delete();
    end
    if (kept) begin
      exp_q.push_back('{memword(r.addr), r.addr + 32'd4});
    end
    @(posedge clock);
    #1;
    cyc++;
    if (reset) begin
      mem_q.delete();
      exp_q.delete();
      exp_req_pc = 32'h0;
      last_due   = 0;
      check("rst_valid", 32'(bus.if_id_valid), 32'h0);
      check("rst_instr", bus.if_id_instruc, 32'h0);
      check("rst_npc", bus.if_id_nextpc, 32'h0);
    end else if (redir) begin
      check("redir_valid", 32'(bus.if_id_valid), 32'h0);
      check("redir_instr", bus.if_id_instruc, 32'h0);
    end else if (bus.ex_if_stall) begin
      check("stall_valid", 32'(bus.if_id_valid), 32'(pre_valid));
      check("stall_instr", bus.if_id_instruc, pre_instr);
      check("stall_npc", bus.if_id_nextpc, pre_npc);
    end else if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check("deliv_valid", 32'(bus.if_id_valid), 32'h1);
      check("deliv_instr", bus.if_id_instruc, w.instr);
      check("deliv_npc", bus.if_id_nextpc, w.npc);
    end else begin
      check("bubble_valid", 32'(bus.if_id_valid), 32'h0);
      check("bubble_instr", bus.if_id_instruc, 32'h0);
      check("bubble_npc", bus.if_id_nextpc, pre_npc);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.ex_if_stall = 1'b0;
    bus.id_if_selpcsource = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] t;
    logic        found;
    bus.ex_if_stall       = 1'b0;
    bus.id_if_selpcsource = 1'b0;
    bus.id_if_selpctype   = 2'b00;
    bus.id_if_rega        = 32'h0;
    bus.id_if_pcimd2ext   = 32'h0;
    bus.id_if_pcindex     = 32'h0;
    bus.mc_if_valid       = 1'b0;
    bus.mc_if_data        = 32'h0;
    reset = 1'b1;
    @(posedge clock);
    #1;

    // 1: reset for three cycles, then the first request goes out immediately
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("t1_en", 32'(bus.if_mc_en), 32'h1);
    check("t1_addr", bus.if_mc_addr, 32'h0);
    check("t1_valid", 32'(bus.if_id_valid), 32'h0);
    check("t1_instr", bus.if_id_instruc, 32'h0);

    // 2: latency 1, back-to-back delivery
    lat = 1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("t2_valid", 32'(bus.if_id_valid), 32'h1);
      check("t2_instr", bus.if_id_instruc, memword(32'(4 * (k - 1))));
      check("t2_npc", bus.if_id_nextpc, 32'(4 * k));
    end

    // 3: stall from reset fills exactly DEPTH entries, release drains with no gap
    do_reset();
    bus.ex_if_stall = 1'b1;
    issues = 0;
    repeat (10) tick();
    check("t3_issues", 32'(issues), 32'(DEPTH));
    check("t3_en_full", 32'(bus.if_mc_en), 32'h0);
    check("t3_held_valid", 32'(bus.if_id_valid), 32'h0);
    bus.ex_if_stall = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("t3_valid", 32'(bus.if_id_valid), 32'h1);
      check("t3_npc", bus.if_id_nextpc, 32'(4 * k));
    end

    // 4: latency 3, three reads in flight, redirect to rega
    do_reset();
    lat = 3;
    repeat (3) tick();
    bus.id_if_selpcsource = 1'b1;
    bus.id_if_selpctype   = 2'b01;
    bus.id_if_rega        = 32'h100;
    tick();
    bus.id_if_selpcsource = 1'b0;
    check("t4_addr", bus.if_mc_addr, 32'h100);
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      tick();
      found = bus.if_id_valid;
    end
    check("t4_found", 32'(found), 32'h1);
    check("t4_instr", bus.if_id_instruc, memword(32'h100));
    check("t4_npc", bus.if_id_nextpc, 32'h104);

    // 5: exception vector redirect, then a redirect during stall is ignored
    bus.id_if_selpcsource = 1'b1;
    bus.id_if_selpctype   = 2'b11;
    tick();
    bus.id_if_selpcsource = 1'b0;
    check("t5_exc_addr", bus.if_mc_addr, 32'd64);
    bus.ex_if_stall = 1'b1;
    repeat (12) tick();
    check("t5_full_en", 32'(bus.if_mc_en), 32'h0);
    bus.id_if_selpcsource = 1'b1;
    bus.id_if_selpctype   = 2'b00;
    bus.id_if_pcimd2ext   = 32'h2000;
    tick();
    bus.id_if_selpcsource = 1'b0;
    check("t5_stall_redir_pc", bus.if_mc_addr, 32'h50);
    bus.ex_if_stall = 1'b0;
    tick();
    check("t5_first_instr", bus.if_id_instruc, memword(32'd64));
    check("t5_first_npc", bus.if_id_nextpc, 32'd68);

    // 6: redirect coinciding with a response, target wraps past the top of memory
    lat = 2;
    repeat (3) tick();
    for (int n = 0; n < 20 && !(mem_q.size() > 0 && mem_q[0].due <= cyc); n++) begin
      tick();
    end
    check("t6_resp_pending", 32'(mem_q.size() > 0 && mem_q[0].due <= cyc), 32'h1);
    bus.id_if_selpcsource = 1'b1;
    bus.id_if_selpctype   = 2'b01;
    bus.id_if_rega        = 32'hFFFF_FFFC;
    tick();
    bus.id_if_selpcsource = 1'b0;
    check("t6_addr", bus.if_mc_addr, 32'hFFFF_FFFC);
    tick();
    check("t6_issue", 32'(last_en), 32'h1);
    check("t6_wrap_addr", bus.if_mc_addr, 32'h0);
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      tick();
      found = bus.if_id_valid;
    end
    check("t6_found", 32'(found), 32'h1);
    check("t6_instr", bus.if_id_instruc, memword(32'hFFFF_FFFC));
    check("t6_npc", bus.if_id_nextpc, 32'h0);

    // randomized traffic: stalls, redirects of every kind, latency changes, one mid-run reset
    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0) lat = 1 + int'($urandom_range(3, 0));
      reset                 = (i == 400 || i == 401);
      bus.ex_if_stall       = ($urandom_range(3, 0) == 0);
      bus.id_if_selpcsource = ($urandom_range(15, 0) == 0);
      bus.id_if_selpctype   = 2'($urandom_range(3, 0));
      t = $urandom;
      bus.id_if_rega = {t[31:2], 2'b00};
      t = $urandom;
      bus.id_if_pcimd2ext = {t[31:2], 2'b00};
      t = $urandom;
      bus.id_if_pcindex = {t[31:2], 2'b00};
      tick();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end
endmodule
